spi_xfer_sched: RTL and testbench

Transfer scheduler between the 16x16 TX/RX word FIFOs and the SPI shift engine in the APB-to-SPI bridge.
- Pops TX words, launches one engine transfer per word and frames bursts with chip-select setup, inter-word gap and hold timing.
- Pushes received words into the RX FIFO.
- Configured from APB control registers; sits between the register block/FIFOs and the SPI engine.

---
 rtl/spi_xfer_sched_pkg.sv | 6 +
 rtl/spi_xfer_sched_if.sv | 39 +++
 rtl/spi_sched_dly_cnt.sv | 17 +
 rtl/spi_xfer_sched.sv | 103 ++++++++++
 tb/tb_spi_xfer_sched.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/spi_xfer_sched_pkg.sv
// spi_xfer_sched_pkg: shared widths and FSM encoding for the SPI transfer scheduler.
package spi_xfer_sched_pkg;
  localparam int DATA_W_DEF = 16;
  localparam int CNT_W_DEF = 8;
  typedef enum logic [2:0] {IDLE, SETUP, LOAD, XFER, GAP, HOLD} state_e;
endpackage

// File: rtl/spi_xfer_sched_if.sv
// spi_xfer_sched_if: FIFO, engine and control signals of the transfer scheduler.
interface spi_xfer_sched_if
  import spi_xfer_sched_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W = CNT_W_DEF
);
  logic i_enable;
  logic i_start;
  logic [CNT_W-1:0] i_burst_len;
  logic i_txf_empty;
  logic [DATA_W-1:0] i_txf_data;
  logic o_txf_rd_en;
  logic o_eng_start;
  logic [DATA_W-1:0] o_eng_data;
  logic i_eng_done;
  logic [DATA_W-1:0] i_eng_rx_data;
  logic i_rxf_full;
  logic o_rxf_wr_en;
  logic [DATA_W-1:0] o_rxf_data;
  logic o_cs_n;
  logic o_busy;
  logic o_frame_done;
  logic o_rx_ovf;
  logic i_clr_ovf;
  logic o_underrun;
  modport master (
    input i_enable, i_start, i_burst_len, i_txf_empty, i_txf_data, i_eng_done, i_eng_rx_data,
    input i_rxf_full, i_clr_ovf,
    output o_txf_rd_en, o_eng_start, o_eng_data, o_rxf_wr_en, o_rxf_data, o_cs_n, o_busy,
    output o_frame_done, o_rx_ovf, o_underrun
  );
  modport slave (
    output i_enable, i_start, i_burst_len, i_txf_empty, i_txf_data, i_eng_done, i_eng_rx_data,
    output i_rxf_full, i_clr_ovf,
    input o_txf_rd_en, o_eng_start, o_eng_data, o_rxf_wr_en, o_rxf_data, o_cs_n, o_busy,
    input o_frame_done, o_rx_ovf, o_underrun
  );
endinterface

// File: rtl/spi_sched_dly_cnt.sv
// spi_sched_dly_cnt: loadable down-counter with zero flag for CS setup/gap/hold and stall timing.
module spi_sched_dly_cnt
  import spi_xfer_sched_pkg::*;
#(
  parameter int W = CNT_W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  output logic         zero_o
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load_i ? val_i : (cnt_q != '0 ? cnt_q - 1'b1 : cnt_q);
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
  assign zero_o = cnt_q == '0;
endmodule

// File: rtl/spi_xfer_sched.sv
// spi_xfer_sched: frames TX FIFO words into SPI engine transfers and pushes RX words back.
// Define SPI_SCHED_STALL_TIMEOUT_EN to abort burst frames starved for STALL_MAX cycles.
module spi_xfer_sched
  import spi_xfer_sched_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int CS_SETUP = 2,
  parameter int IDLE_GAP = 1,
  parameter int CS_HOLD = 2,
  parameter int STALL_MAX = 255
) (
  input logic i_clk,
  input logic i_rst,
  spi_xfer_sched_if.master bus
);
  state_e state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d, dly_val;
  logic cont_q, cont_d, cs_n_q, fd_q, ovf_q, launch, push, drop, dly_zero;
`ifdef SPI_SCHED_STALL_TIMEOUT_EN
  logic stall_abort, unr_q;
`endif
  always_comb begin
    state_d = state_q;
    rem_d = rem_q;
    cont_d = cont_q;
    launch = 1'b0;
    push = 1'b0;
    drop = 1'b0;
`ifdef SPI_SCHED_STALL_TIMEOUT_EN
    stall_abort = 1'b0;
`endif
    case (state_q)
      IDLE: if (bus.i_enable && bus.i_start && !bus.i_txf_empty) begin
        state_d = SETUP;
        rem_d = bus.i_burst_len;
        cont_d = bus.i_burst_len == '0;
      end
      SETUP: state_d = !bus.i_enable ? HOLD : dly_zero ? LOAD : SETUP;
      LOAD: begin
        if (!bus.i_enable) state_d = HOLD;
        else if (!bus.i_txf_empty) begin
          launch = 1'b1;
          state_d = XFER;
        end
        else if (cont_q) state_d = HOLD;
`ifdef SPI_SCHED_STALL_TIMEOUT_EN
        else if (dly_zero) begin
          state_d = HOLD;
          stall_abort = 1'b1;
        end
`endif
      end
      XFER: if (bus.i_eng_done) begin
        push = !bus.i_rxf_full;
        drop = bus.i_rxf_full;
        rem_d = rem_q - 1'b1;
        state_d = (!bus.i_enable || (!cont_q && rem_q == CNT_W'(1))) ? HOLD : IDLE_GAP == 0 ? LOAD : GAP;
      end
      GAP: state_d = !bus.i_enable ? HOLD : dly_zero ? LOAD : GAP;
      HOLD: state_d = dly_zero ? IDLE : HOLD;
      default: state_d = IDLE;
    endcase
  end
  // The shared counter is reloaded on every state change; LOAD gets the stall budget.
  always_comb dly_val = state_d == SETUP ? CNT_W'(CS_SETUP - 1) :
                        state_d == GAP   ? CNT_W'(IDLE_GAP - 1) :
                        state_d == HOLD  ? CNT_W'(CS_HOLD - 1) : CNT_W'(STALL_MAX - 1);
  spi_sched_dly_cnt #(.W(CNT_W)) u_dly (
    .clk(i_clk), .rst(i_rst), .load_i(state_d != state_q), .val_i(dly_val), .zero_o(dly_zero)
  );
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      rem_q <= '0;
      cont_q <= 1'b0;
      cs_n_q <= 1'b1;
      fd_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q <= rem_d;
      cont_q <= cont_d;
      cs_n_q <= state_d == IDLE;
      fd_q <= state_q == HOLD && state_d == IDLE;
      ovf_q <= drop | (ovf_q & ~bus.i_clr_ovf);
    end
  end
`ifdef SPI_SCHED_STALL_TIMEOUT_EN
  always_ff @(posedge i_clk) unr_q <= i_rst ? 1'b0 : stall_abort | (unr_q & ~bus.i_clr_ovf);
  assign bus.o_underrun = unr_q;
`else
  assign bus.o_underrun = 1'b0;
`endif
  assign bus.o_txf_rd_en = launch;
  assign bus.o_eng_start = launch;
  assign bus.o_eng_data = bus.i_txf_data;
  assign bus.o_rxf_wr_en = push;
  assign bus.o_rxf_data = bus.i_eng_rx_data;
  assign bus.o_cs_n = cs_n_q;
  assign bus.o_busy = state_q != IDLE;
  assign bus.o_frame_done = fd_q;
  assign bus.o_rx_ovf = ovf_q;
endmodule

// File: tb/tb_spi_xfer_sched.sv
// tb_spi_xfer_sched: directed scenarios against FIFO and engine models of the scheduler.
module tb_spi_xfer_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  spi_xfer_sched_if bus ();
  spi_xfer_sched dut (.i_clk(clk), .i_rst(rst), .bus(bus));
  int checks = 0, errors = 0;
  logic [15:0] fifo [0:15];
  int head = 0, tail = 0;
  int ecnt = 0;
  logic [15:0] eword = '0;
  assign bus.i_txf_empty = head == tail;
  assign bus.i_txf_data = fifo[head[3:0]];
  assign bus.i_eng_done = ecnt == 1;
  assign bus.i_eng_rx_data = ~eword;
  int cyc = 0, n_pop = 0, n_start = 0, n_push = 0, n_fd = 0;
  int fall_cyc = 0, rise_cyc = 0, last_done_cyc = 0, fd_cyc = 0;
  int sc_log [0:63];
  logic [15:0] start_log [0:63];
  logic [15:0] push_log [0:63];
  logic prev_cs = 1'b1, busy_at_fd = 1'b1;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.o_txf_rd_en) begin
      head <= head + 1;
      n_pop <= n_pop + 1;
    end
    if (bus.o_eng_start) begin
      ecnt <= 8;
      eword <= bus.o_eng_data;
      start_log[n_start[5:0]] <= bus.o_eng_data;
      sc_log[n_start[5:0]] <= cyc;
      n_start <= n_start + 1;
    end else if (ecnt > 0) ecnt <= ecnt - 1;
    if (bus.i_eng_done) last_done_cyc <= cyc;
    if (bus.o_rxf_wr_en) begin
      push_log[n_push[5:0]] <= bus.o_rxf_data;
      n_push <= n_push + 1;
    end
    if (prev_cs && !bus.o_cs_n) fall_cyc <= cyc;
    if (!prev_cs && bus.o_cs_n) rise_cyc <= cyc;
    prev_cs <= bus.o_cs_n;
    if (bus.o_frame_done) begin
      n_fd <= n_fd + 1;
      fd_cyc <= cyc;
      busy_at_fd <= bus.o_busy;
    end
  end
  task automatic push_w(input logic [15:0] w);
    fifo[tail[3:0]] = w;
    tail = tail + 1;
  endtask
  task automatic start_frame(input logic [7:0] len);
    @(negedge clk);
    bus.i_burst_len = len;
    bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
  endtask
  task automatic wait_fd(input int base, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk);
      ok = n_fd > base;
    end
  endtask
  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = bus.i_eng_done;
    end
  endtask
  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (bus.o_cs_n !== 1'b1) begin errors++; $display("FAIL reset_cs_n: got %b exp 1", bus.o_cs_n); end
    checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", bus.o_busy); end
    checks++; if ({bus.o_rx_ovf, bus.o_underrun, bus.o_frame_done} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b exp 000", {bus.o_rx_ovf, bus.o_underrun, bus.o_frame_done}); end
    checks++; if ({bus.o_txf_rd_en, bus.o_eng_start, bus.o_rxf_wr_en} !== 3'b000) begin errors++; $display("FAIL reset_strobes: got %b exp 000", {bus.o_txf_rd_en, bus.o_eng_start, bus.o_rxf_wr_en}); end
    rst = 1'b0;
    push_w(16'h5555);
    start_frame(8'd1);
    checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL start_disabled: busy got %b exp 0", bus.o_busy); end
    tail = head;
    bus.i_enable = 1'b1;
    start_frame(8'd1);
    checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL start_empty: busy got %b exp 0", bus.o_busy); end
  endtask
  task automatic test_burst3();
    int bp = n_pop, bs = n_start, bq = n_push, bf = n_fd;
    logic [15:0] w [0:2];
    bit ok;
    w[0] = 16'hA5A5; w[1] = 16'h1234; w[2] = 16'hFFFF;
    for (int i = 0; i < 3; i++) push_w(w[i]);
    start_frame(8'd3);
    wait_fd(bf, ok);
    checks++; if (!ok) begin errors++; $display("FAIL burst3_timeout: frame_done got none exp 1"); end
    checks++; if (n_pop - bp !== 3 || n_start - bs !== 3) begin errors++; $display("FAIL burst3_count: pops %0d starts %0d exp 3 3", n_pop - bp, n_start - bs); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (start_log[bs + i] !== w[i]) begin errors++; $display("FAIL burst3_tx%0d: got %h exp %h", i, start_log[bs + i], w[i]); end
      checks++; if (push_log[bq + i] !== ~w[i]) begin errors++; $display("FAIL burst3_rx%0d: got %h exp %h", i, push_log[bq + i], ~w[i]); end
    end
    checks++; if (n_push - bq !== 3 || n_fd - bf !== 1) begin errors++; $display("FAIL burst3_push_fd: pushes %0d fds %0d exp 3 1", n_push - bq, n_fd - bf); end
    checks++; if (sc_log[bs] - fall_cyc !== 2) begin errors++; $display("FAIL burst3_setup: got %0d exp 2", sc_log[bs] - fall_cyc); end
    checks++; if (rise_cyc - last_done_cyc !== 3) begin errors++; $display("FAIL burst3_hold: got %0d exp 3", rise_cyc - last_done_cyc); end
    checks++; if (sc_log[bs + 1] - sc_log[bs] !== 10) begin errors++; $display("FAIL burst3_gap: got %0d exp 10", sc_log[bs + 1] - sc_log[bs]); end
    checks++; if (fd_cyc !== rise_cyc || busy_at_fd !== 1'b0) begin errors++; $display("FAIL burst3_fd_align: fd %0d rise %0d busy %b exp equal 0", fd_cyc, rise_cyc, busy_at_fd); end
  endtask
  task automatic test_continuous();
    int bp = n_pop, bq = n_push, bf = n_fd;
    bit ok;
    for (int i = 0; i < 5; i++) push_w(16'h0C00 + 16'(i));
    start_frame(8'd0);
    wait_fd(bf, ok);
    checks++; if (!ok) begin errors++; $display("FAIL cont_timeout: frame_done got none exp 1"); end
    checks++; if (n_pop - bp !== 5 || n_push - bq !== 5) begin errors++; $display("FAIL cont_count: pops %0d pushes %0d exp 5 5", n_pop - bp, n_push - bq); end
    checks++; if (push_log[bq + 4] !== 16'hF3FB) begin errors++; $display("FAIL cont_last_rx: got %h exp f3fb", push_log[bq + 4]); end
    checks++; if (fd_cyc - last_done_cyc !== 5) begin errors++; $display("FAIL cont_end: got %0d exp 5", fd_cyc - last_done_cyc); end
    checks++; if (busy_at_fd !== 1'b0 || n_fd - bf !== 1) begin errors++; $display("FAIL cont_fd: busy %b fds %0d exp 0 1", busy_at_fd, n_fd - bf); end
  endtask
  task automatic test_rx_ovf();
    int bq = n_push, bf = n_fd;
    bit ok;
    push_w(16'h0101); push_w(16'h0202); push_w(16'h0303);
    start_frame(8'd3);
    wait_done(ok);
    wait_done(ok);
    bus.i_rxf_full = 1'b1;
    @(negedge clk);
    bus.i_rxf_full = 1'b0;
    wait_fd(bf, ok);
    checks++; if (n_push - bq !== 2) begin errors++; $display("FAIL ovf_push_count: got %0d exp 2", n_push - bq); end
    checks++; if (push_log[bq] !== 16'hFEFE || push_log[bq + 1] !== 16'hFCFC) begin errors++; $display("FAIL ovf_push_data: got %h %h exp fefe fcfc", push_log[bq], push_log[bq + 1]); end
    repeat (5) @(negedge clk);
    checks++; if (bus.o_rx_ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b exp 1", bus.o_rx_ovf); end
    bus.i_clr_ovf = 1'b1;
    @(negedge clk);
    bus.i_clr_ovf = 1'b0;
    checks++; if (bus.o_rx_ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b exp 0", bus.o_rx_ovf); end
    bq = n_push; bf = n_fd;
    push_w(16'h0404);
    start_frame(8'd1);
    wait_done(ok);
    bus.i_rxf_full = 1'b1;
    bus.i_clr_ovf = 1'b1;
    @(negedge clk);
    bus.i_rxf_full = 1'b0;
    bus.i_clr_ovf = 1'b0;
    checks++; if (bus.o_rx_ovf !== 1'b1) begin errors++; $display("FAIL ovf_set_wins: got %b exp 1", bus.o_rx_ovf); end
    wait_fd(bf, ok);
    checks++; if (n_push - bq !== 0) begin errors++; $display("FAIL ovf_drop: pushes got %0d exp 0", n_push - bq); end
    bus.i_clr_ovf = 1'b1;
    @(negedge clk);
    bus.i_clr_ovf = 1'b0;
  endtask
  task automatic test_reset_mid();
    int bs = n_start, bq = n_push, bf = n_fd;
    push_w(16'h7777); push_w(16'h8888);
    start_frame(8'd2);
    for (int i = 0; i < 20 && n_start == bs; i++) @(negedge clk);
    checks++; if (n_start - bs !== 1) begin errors++; $display("FAIL rstmid_launch: starts %0d exp 1", n_start - bs); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (bus.o_cs_n !== 1'b1 || bus.o_busy !== 1'b0) begin errors++; $display("FAIL rstmid_state: cs_n %b busy %b exp 1 0", bus.o_cs_n, bus.o_busy); end
    checks++; if ({bus.o_txf_rd_en, bus.o_eng_start, bus.o_rxf_wr_en, bus.o_frame_done} !== 4'b0000) begin errors++; $display("FAIL rstmid_strobes: got %b exp 0000", {bus.o_txf_rd_en, bus.o_eng_start, bus.o_rxf_wr_en, bus.o_frame_done}); end
    repeat (12) @(negedge clk);
    checks++; if (n_push - bq !== 0 || n_fd - bf !== 0 || bus.o_busy !== 1'b0) begin errors++; $display("FAIL rstmid_late_done: pushes %0d fds %0d busy %b exp 0 0 0", n_push - bq, n_fd - bf, bus.o_busy); end
    tail = head;
  endtask
  task automatic test_enable_drop();
    int bp = n_pop, bq = n_push, bf = n_fd;
    bit ok;
    for (int i = 0; i < 4; i++) push_w(16'h2200 + 16'(i));
    start_frame(8'd4);
    wait_done(ok);
    wait_done(ok);
    @(negedge clk);
    bus.i_enable = 1'b0;
    wait_fd(bf, ok);
    checks++; if (!ok) begin errors++; $display("FAIL endrop_timeout: frame_done got none exp 1"); end
    checks++; if (n_pop - bp !== 2 || n_push - bq !== 2) begin errors++; $display("FAIL endrop_count: pops %0d pushes %0d exp 2 2", n_pop - bp, n_push - bq); end
    checks++; if (fd_cyc - last_done_cyc !== 4) begin errors++; $display("FAIL endrop_hold: got %0d exp 4", fd_cyc - last_done_cyc); end
    checks++; if (bus.o_cs_n !== 1'b1 || bus.o_busy !== 1'b0) begin errors++; $display("FAIL endrop_idle: cs_n %b busy %b exp 1 0", bus.o_cs_n, bus.o_busy); end
    bus.i_enable = 1'b1;
    tail = head;
  endtask
  task automatic test_stall();
    int bp = n_pop, bf = n_fd;
    bit ok;
    push_w(16'h3131);
    start_frame(8'd4);
`ifdef SPI_SCHED_STALL_TIMEOUT_EN
    wait_fd(bf, ok);
    checks++; if (!ok) begin errors++; $display("FAIL stall_abort_timeout: frame_done got none exp 1"); end
    checks++; if (bus.o_underrun !== 1'b1 || n_pop - bp !== 1) begin errors++; $display("FAIL stall_underrun: flag %b pops %0d exp 1 1", bus.o_underrun, n_pop - bp); end
    checks++; if (bus.o_cs_n !== 1'b1) begin errors++; $display("FAIL stall_cs_n: got %b exp 1", bus.o_cs_n); end
    bus.i_clr_ovf = 1'b1;
    @(negedge clk);
    bus.i_clr_ovf = 1'b0;
    checks++; if (bus.o_underrun !== 1'b0) begin errors++; $display("FAIL stall_clear: got %b exp 0", bus.o_underrun); end
`else
    repeat (300) @(negedge clk);
    checks++; if (bus.o_cs_n !== 1'b0 || bus.o_busy !== 1'b1) begin errors++; $display("FAIL stall_hold_low: cs_n %b busy %b exp 0 1", bus.o_cs_n, bus.o_busy); end
    checks++; if (bus.o_underrun !== 1'b0 || n_pop - bp !== 1) begin errors++; $display("FAIL stall_state: underrun %b pops %0d exp 0 1", bus.o_underrun, n_pop - bp); end
    push_w(16'h3232); push_w(16'h3333); push_w(16'h3434);
    wait_fd(bf, ok);
    checks++; if (!ok || n_pop - bp !== 4) begin errors++; $display("FAIL stall_resume: done %b pops %0d exp 1 4", ok, n_pop - bp); end
`endif
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.i_enable = 1'b0;
    bus.i_start = 1'b0;
    bus.i_burst_len = '0;
    bus.i_rxf_full = 1'b0;
    bus.i_clr_ovf = 1'b0;
    test_reset();
    test_burst3();
    test_continuous();
    test_rx_ovf();
    test_reset_mid();
    test_enable_drop();
    test_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
